fetch_decode_skid_reg: RTL
==========================

// Module: fetch_decode_skid_reg
// PURPOSE
//  Parametrised IF->ID pipeline register with valid/ready handshake and a 2-entry skid buffer.
//  Sits between instruction fetch and decode. Carries {pc, inst} with full throughput.
//  Handles stall by back-pressure and flush by dropping both entries.
//  Counts downstream stall cycles for performance tracking.
// PARAMETERS
//  PC_W      32            width of program-counter field
//  INST_W    32            width of instruction field
//  NOP_INST  {INST_W{1'b0}} value driven on out_inst_o when the stage holds no valid entry
//  CNT_W     16            width of stall-cycle counter (saturating)
// PORTS
//  clk_i        in   1       clock; all state updates on rising edge
//  rst_i        in   1       synchronous, active-high reset
//  in_valid_i   in   1       fetch presents valid {pc, inst}
//  in_ready_o   out  1       stage can accept; = !skid_valid && !rst_i
//  in_pc_i      in   PC_W    fetched PC
//  in_inst_i    in   INST_W  fetched instruction
//  flush_i      in   1       discard all held entries (branch/jump redirect)
//  out_valid_o  out  1       decode-side entry valid
//  out_ready_i  in   1       decode accepts (low = hazard stall)
//  out_pc_o     out  PC_W    PC of held entry
//  out_inst_o   out  INST_W  instruction of held entry, NOP_INST when invalid
//  clr_cnt_i    in   1       synchronous clear of stall counter
//  stall_cnt_o  out  CNT_W   cycles with out_valid_o=1 and out_ready_i=0
// BEHAVIOUR
//  State: main reg {m_valid, m_pc, m_inst} drives outputs directly; skid reg {s_valid, s_pc, s_inst}.
//  acc = in_valid_i && in_ready_o ; drn = out_valid_o && out_ready_i.
//  Reset (rst_i=1): m_valid=s_valid=0, out_pc_o=0, out_inst_o=NOP_INST, stall_cnt_o=0, in_ready_o=0.
//  Priority per cycle: rst_i > flush_i > normal update.
//  flush_i: m_valid<=0, s_valid<=0, out_inst_o<=NOP_INST, out_pc_o holds; a same-cycle acc is dropped.
//  Normal update:
//   - main empty or drn: if s_valid -> main<=skid, s_valid<=0; else if acc -> main<=input;
//     else m_valid<=0, out_inst_o<=NOP_INST.
//   - main full and !drn and acc: skid<=input, s_valid<=1 (in_ready_o falls next cycle).
//   - in_ready_o=0 whenever s_valid=1, so acc and skid drain never coincide.
//  Latency: 1 cycle from acc into empty stage to out_valid_o=1. Throughput: 1 entry/cycle
//   with out_ready_i held high. No entry is lost or duplicated; order is strictly FIFO.
//  out_pc_o/out_inst_o stable while out_valid_o=1 and out_ready_i=0.
//  Stall counter: +1 each cycle out_valid_o && !out_ready_i; saturates at 2^CNT_W-1;
//   clr_cnt_i has priority over increment; not affected by flush_i.
// TESTING
//  1) Reset, then in_valid_i=1 pc=0x100 inst=0xDEADBEEF, out_ready_i=1 -> next cycle out_valid_o=1,
//     out_pc_o=0x100, out_inst_o=0xDEADBEEF; stream of 8 back-to-back entries emerges 1/cycle, in order.
//  2) Stage full, out_ready_i=0, in_valid_i=1 pc=0x104 -> skid captures, in_ready_o=0 next cycle;
//     out_ready_i=1 for 2 cycles -> outputs 0x100 then 0x104, in_ready_o returns to 1.
//  3) Both entries full, flush_i=1 -> next cycle out_valid_o=0, out_inst_o=NOP_INST, in_ready_o=1;
//     input offered in flush cycle never appears at output.
//  4) out_valid_o=1, out_ready_i=0 for 5 cycles -> stall_cnt_o=5, out data unchanged throughout;
//     clr_cnt_i=1 with stall active -> stall_cnt_o=0 next cycle.
//  5) CNT_W=4, stall 20 cycles -> stall_cnt_o=15 (saturated).
//  6) Assert rst_i mid-stream with both entries full -> next cycle all outputs at reset values,
//     in_ready_o=0 while rst_i high, =1 first cycle after release.

Source files
------------

// File: rtl/fetch_decode_skid_reg.sv
// IF->ID pipeline register with a one-entry skid: 1-cycle latency, full throughput.
// Back-pressure: in_ready_o drops the cycle after the skid fills; flush drops both entries.
module fetch_decode_skid_reg #(
  parameter int                  PC_W     = 32,
  parameter int                  INST_W   = 32,
  parameter logic [INST_W-1:0]   NOP_INST = {INST_W{1'b0}},
  parameter int                  CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PC_W-1:0]   in_pc_i,
  input  logic [INST_W-1:0] in_inst_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   out_pc_o,
  output logic [INST_W-1:0] out_inst_o,
  input  logic              clr_cnt_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              m_valid;
  logic [PC_W-1:0]   m_pc;
  logic [INST_W-1:0] m_inst;
  logic              s_valid;
  logic [PC_W-1:0]   s_pc;
  logic [INST_W-1:0] s_inst;
  logic              acc;
  logic              drn;

  assign in_ready_o  = !s_valid && !rst_i;
  assign acc         = in_valid_i && in_ready_o;
  assign drn         = m_valid && out_ready_i;
  assign out_valid_o = m_valid;
  assign out_pc_o    = m_pc;
  assign out_inst_o  = m_valid ? m_inst : NOP_INST;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_valid <= 1'b0;
      m_pc    <= '0;
      m_inst  <= NOP_INST;
      s_valid <= 1'b0;
      s_pc    <= '0;
      s_inst  <= NOP_INST;
    end else if (flush_i) begin
      // PC is left as-is so the last issued address stays observable.
      m_valid <= 1'b0;
      m_inst  <= NOP_INST;
      s_valid <= 1'b0;
    end else if (!m_valid || drn) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        m_pc    <= s_pc;
        m_inst  <= s_inst;
        s_valid <= 1'b0;
      end else if (acc) begin
        m_valid <= 1'b1;
        m_pc    <= in_pc_i;
        m_inst  <= in_inst_i;
      end else begin
        m_valid <= 1'b0;
        m_inst  <= NOP_INST;
      end
    end else if (acc) begin
      s_valid <= 1'b1;
      s_pc    <= in_pc_i;
      s_inst  <= in_inst_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (clr_cnt_i) begin
      stall_cnt_o <= '0;
    end else if (m_valid && !out_ready_i && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule
